// File: rtl/click_pkg.sv
// Shared definitions for the gesture blocks: click FSM state encoding and the
// window-length derivation used to size their timers.
package click_pkg;

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_WAIT = 1'b1;

    typedef enum logic {
        IDLE = STATE_IDLE,
        WAIT = STATE_WAIT
    } click_state_t;

    // Window length in clock cycles; integer division first keeps it in int range.
    function automatic int window_cycles(input int clk_freq_hz, input int window_ms);
        return clk_freq_hz / 1000 * window_ms;
    endfunction

endpackage

// File: rtl/window_timer.sv
// Loadable down-counter that saturates at zero and flags when it gets there.
module window_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_s_p,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    // Load wins over decrement; the counter holds at zero rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst_s_p) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/click_classifier.sv
// Classifies one-shot press pulses into single or double clicks using a
// configurable window, emitting one registered one-cycle pulse per gesture.
module click_classifier
    import click_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int WINDOW_MS   = 300
) (
    input  logic clk,
    input  logic rst_s_p,
    input  logic pulse_in,
    output logic single_click,
    output logic double_click,
    output logic busy
);

    localparam int WINDOW_CYCLES = window_cycles(CLK_FREQ_HZ, WINDOW_MS);
    localparam int CNT_W         = (WINDOW_CYCLES < 1) ? 1 : $clog2(WINDOW_CYCLES + 1);

    generate
        if (WINDOW_CYCLES < 1) begin : g_bad_window
            $error("click_classifier: WINDOW_CYCLES must be at least 1");
        end
    endgenerate

    click_state_t state;
    logic         timer_load;
    logic         timer_enable;
    logic         timer_zero;

    // The first press opens the window; the timer only runs while waiting for
    // a second press, so a press in WAIT never competes with a decrement.
    assign timer_load   = (state == IDLE) && pulse_in;
    assign timer_enable = (state == WAIT) && !pulse_in;

    window_timer #(
        .WIDTH (CNT_W)
    ) u_window_timer (
        .clk     (clk),
        .rst_s_p (rst_s_p),
        .load    (timer_load),
        .enable  (timer_enable),
        .value   (CNT_W'(WINDOW_CYCLES - 1)),
        .zero    (timer_zero)
    );

    // A press in WAIT beats a simultaneous timeout; a press arriving while the
    // previous gesture's pulse is out is treated as the start of a new one.
    always_ff @(posedge clk) begin
        if (rst_s_p) begin
            state        <= IDLE;
            single_click <= 1'b0;
            double_click <= 1'b0;
        end else begin
            single_click <= 1'b0;
            double_click <= 1'b0;
            case (state)
                IDLE: begin
                    if (pulse_in) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (pulse_in) begin
                        double_click <= 1'b1;
                        state        <= IDLE;
                    end else if (timer_zero) begin
                        single_click <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == WAIT);

endmodule

// File: tb/tb_click_classifier.sv
// Directed bench for click_classifier with a 10-cycle window; cycle 0 is the
// first cycle after reset is released, presses are driven for whole cycles.
module tb_click_classifier;

    logic clk;
    logic rst_s_p;
    logic pulse_in;
    logic single_click;
    logic double_click;
    logic busy;

    int checks;
    int errors;

    click_classifier #(
        .CLK_FREQ_HZ (1000),
        .WINDOW_MS   (10)
    ) dut (
        .clk          (clk),
        .rst_s_p      (rst_s_p),
        .pulse_in     (pulse_in),
        .single_click (single_click),
        .double_click (double_click),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Holds reset for two edges and leaves the bench #1 into cycle 0.
    task automatic apply_reset();
        rst_s_p  = 1'b1;
        pulse_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_s_p = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            checks++;
            if ({single_click, double_click, busy} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL reset_idle cycle %0d: got s/d/b=%b%b%b, expected 000", c, single_click, double_click, busy);
            end
            pulse_in = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_single();
        apply_reset();
        for (int c = 0; c < 26; c++) begin
            checks += 3;
            if (busy !== ((c >= 6) && (c <= 15))) begin
                errors++;
                $display("[TB] FAIL single_busy cycle %0d: got %b, expected %b", c, busy, (c >= 6) && (c <= 15));
            end
            if (single_click !== (c == 16)) begin
                errors++;
                $display("[TB] FAIL single_pulse cycle %0d: got %b, expected %b", c, single_click, c == 16);
            end
            if (double_click !== 1'b0) begin
                errors++;
                $display("[TB] FAIL single_nodouble cycle %0d: got %b, expected 0", c, double_click);
            end
            pulse_in = (c == 5);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_double();
        apply_reset();
        for (int c = 0; c < 26; c++) begin
            checks += 3;
            if (busy !== ((c >= 6) && (c <= 9))) begin
                errors++;
                $display("[TB] FAIL double_busy cycle %0d: got %b, expected %b", c, busy, (c >= 6) && (c <= 9));
            end
            if (double_click !== (c == 10)) begin
                errors++;
                $display("[TB] FAIL double_pulse cycle %0d: got %b, expected %b", c, double_click, c == 10);
            end
            if (single_click !== 1'b0) begin
                errors++;
                $display("[TB] FAIL double_nosingle cycle %0d: got %b, expected 0", c, single_click);
            end
            pulse_in = (c == 5) || (c == 9);
            @(posedge clk);
            #1;
        end
    endtask

    // Second press on the last cycle of the window still counts as a double.
    task automatic test_boundary_inside();
        apply_reset();
        for (int c = 0; c < 28; c++) begin
            checks += 3;
            if (busy !== ((c >= 6) && (c <= 15))) begin
                errors++;
                $display("[TB] FAIL edge_in_busy cycle %0d: got %b, expected %b", c, busy, (c >= 6) && (c <= 15));
            end
            if (double_click !== (c == 16)) begin
                errors++;
                $display("[TB] FAIL edge_in_double cycle %0d: got %b, expected %b", c, double_click, c == 16);
            end
            if (single_click !== 1'b0) begin
                errors++;
                $display("[TB] FAIL edge_in_nosingle cycle %0d: got %b, expected 0", c, single_click);
            end
            pulse_in = (c == 5) || (c == 15);
            @(posedge clk);
            #1;
        end
    endtask

    // One cycle later the first gesture has timed out and the press starts anew.
    task automatic test_boundary_outside();
        apply_reset();
        for (int c = 0; c < 32; c++) begin
            checks += 3;
            if (busy !== (((c >= 6) && (c <= 15)) || ((c >= 17) && (c <= 26)))) begin
                errors++;
                $display("[TB] FAIL edge_out_busy cycle %0d: got %b, expected %b", c, busy,
                         ((c >= 6) && (c <= 15)) || ((c >= 17) && (c <= 26)));
            end
            if (single_click !== ((c == 16) || (c == 27))) begin
                errors++;
                $display("[TB] FAIL edge_out_single cycle %0d: got %b, expected %b", c, single_click, (c == 16) || (c == 27));
            end
            if (double_click !== 1'b0) begin
                errors++;
                $display("[TB] FAIL edge_out_nodouble cycle %0d: got %b, expected 0", c, double_click);
            end
            pulse_in = (c == 5) || (c == 16);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int c = 0; c < 26; c++) begin
            checks += 3;
            if (busy !== (((c >= 6) && (c <= 7)) || ((c >= 9) && (c <= 18)))) begin
                errors++;
                $display("[TB] FAIL b2b_busy cycle %0d: got %b, expected %b", c, busy,
                         ((c >= 6) && (c <= 7)) || ((c >= 9) && (c <= 18)));
            end
            if (double_click !== (c == 8)) begin
                errors++;
                $display("[TB] FAIL b2b_double cycle %0d: got %b, expected %b", c, double_click, c == 8);
            end
            if (single_click !== (c == 19)) begin
                errors++;
                $display("[TB] FAIL b2b_single cycle %0d: got %b, expected %b", c, single_click, c == 19);
            end
            pulse_in = (c == 5) || (c == 7) || (c == 8);
            @(posedge clk);
            #1;
        end
    endtask

    // Reset mid-window drops the gesture; a press right after is a fresh first press.
    task automatic test_reset_mid_window();
        apply_reset();
        for (int c = 0; c < 30; c++) begin
            checks += 3;
            if (busy !== (((c >= 6) && (c <= 9)) || ((c >= 13) && (c <= 22)))) begin
                errors++;
                $display("[TB] FAIL rst_mid_busy cycle %0d: got %b, expected %b", c, busy,
                         ((c >= 6) && (c <= 9)) || ((c >= 13) && (c <= 22)));
            end
            if (single_click !== (c == 23)) begin
                errors++;
                $display("[TB] FAIL rst_mid_single cycle %0d: got %b, expected %b", c, single_click, c == 23);
            end
            if (double_click !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rst_mid_nodouble cycle %0d: got %b, expected 0", c, double_click);
            end
            rst_s_p  = (c == 9);
            pulse_in = (c == 5) || (c == 9) || (c == 12);
            @(posedge clk);
            #1;
        end
        rst_s_p = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_s_p  = 1'b1;
        pulse_in = 1'b0;
        $display("[TB] starting click_classifier bench");
        test_reset();
        test_single();
        test_double();
        test_boundary_inside();
        test_boundary_outside();
        test_back_to_back();
        test_reset_mid_window();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
